// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the multicycle CPU: opcodes, immediate-extension
// encodings, instruction field positions and decoder state/field types.
package cpu_isa_pkg;

  localparam int INS_W = 32;

  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;
  localparam int JT_MSB    = 25;
  localparam int JT_LSB    = 0;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDI  = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b010000;
  localparam logic [5:0] OP_AND   = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLT   = 6'b100110;
  localparam logic [5:0] OP_SLTIU = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [1:0] EXT_SHAMT = 2'b00;
  localparam logic [1:0] EXT_ZERO  = 2'b01;
  localparam logic [1:0] EXT_SIGN  = 2'b10;
  localparam logic [1:0] EXT_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DECODE = 2'b01,
    ST_HOLD   = 2'b10,
    ST_HALT   = 2'b11
  } dec_state_e;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] jtarget;
  } dec_fields_t;

  // Raw field split; Immediate already carries shamt in bits 10:6.
  function automatic dec_fields_t slice_fields(input logic [INS_W-1:0] ins);
    dec_fields_t f;
    f.opcode  = ins[OPC_MSB:OPC_LSB];
    f.rs      = ins[RS_MSB:RS_LSB];
    f.rt      = ins[RT_MSB:RT_LSB];
    f.rd      = ins[RD_MSB:RD_LSB];
    f.imm     = ins[IMM_MSB:IMM_LSB];
    f.jtarget = ins[JT_MSB:JT_LSB];
    return f;
  endfunction

endpackage

// File: rtl/instruction_field_decoder_if.sv
// Fetch-side handshake plus decoded-field bus between instruction memory,
// the field decoder and its consumers (control unit, register file, extender).
interface instruction_field_decoder_if;
  import cpu_isa_pkg::*;

  logic [INS_W-1:0] InsIn;
  logic             InsValid;
  logic             InsReady;
  logic             DecAck;
  logic             DecValid;
  logic [5:0]       Opcode;
  logic [4:0]       Rs;
  logic [4:0]       Rt;
  logic [4:0]       Rd;
  logic [15:0]      Immediate;
  logic [1:0]       ExtSel;
  logic [25:0]      JumpTarget;
  logic             IllegalOp;
  logic             Halted;

  modport slave (
    input  InsIn, InsValid, DecAck,
    output InsReady, DecValid, Opcode, Rs, Rt, Rd, Immediate, ExtSel,
           JumpTarget, IllegalOp, Halted
  );

  modport master (
    output InsIn, InsValid, DecAck,
    input  InsReady, DecValid, Opcode, Rs, Rt, Rd, Immediate, ExtSel,
           JumpTarget, IllegalOp, Halted
  );

endinterface

// File: rtl/ext_sel_lut.sv
// Combinational opcode classifier: immediate-extension mode and illegal flag.
// Shared with the control unit so both agree on what the ISA contains.
module ext_sel_lut
  import cpu_isa_pkg::*;
(
  input  logic [5:0] opcode_i,
  output logic [1:0] ext_sel_o,
  output logic       illegal_o
);

  // Opcode table lookup; anything unlisted is reserved/illegal.
  always_comb begin
    ext_sel_o = EXT_RSVD;
    illegal_o = 1'b1;
    case (opcode_i)
      OP_ADDI, OP_SW, OP_LW, OP_BEQ: begin
        ext_sel_o = EXT_SIGN;
        illegal_o = 1'b0;
      end
      OP_ORI, OP_SLTIU: begin
        ext_sel_o = EXT_ZERO;
        illegal_o = 1'b0;
      end
      OP_SLL: begin
        ext_sel_o = EXT_SHAMT;
        illegal_o = 1'b0;
      end
      // Legal opcodes that never use the immediate get a harmless zero-extend.
      OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SLT, OP_J, OP_JR, OP_JAL, OP_HALT: begin
        ext_sel_o = EXT_ZERO;
        illegal_o = 1'b0;
      end
      default: begin
        ext_sel_o = EXT_RSVD;
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instruction_field_decoder.sv
// Instruction register with valid/ready intake, registered field split,
// opcode classification and a sticky halt state that only reset leaves.
module instruction_field_decoder
  import cpu_isa_pkg::*;
#(
  parameter int             IW           = 32,
  parameter logic [IW-1:0]  RESET_PC_INS = 32'h0000_0000
) (
  input  logic                        CLK,
  input  logic                        RST,
  instruction_field_decoder_if.slave  bus
);

  dec_state_e  state_q, state_d;
  logic [IW-1:0] ir_q, ir_d;
  logic        ready_q, ready_d;
  logic        dec_valid_q, dec_valid_d;
  logic        halted_q, halted_d;
  dec_fields_t fields_q, fields_d;
  logic [1:0]  ext_sel_q, ext_sel_d;
  logic        illegal_q, illegal_d;

  logic [1:0]  lut_ext_sel_s;
  logic        lut_illegal_s;

  ext_sel_lut u_ext_sel_lut (
    .opcode_i  (ir_q[OPC_MSB:OPC_LSB]),
    .ext_sel_o (lut_ext_sel_s),
    .illegal_o (lut_illegal_s)
  );

  // Next-state and next-output logic for the intake/decode/hold/halt sequence.
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    dec_valid_d = dec_valid_q;
    halted_d    = halted_q;
    fields_d    = fields_q;
    ext_sel_d   = ext_sel_q;
    illegal_d   = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.InsValid && ready_q) begin
          ir_d    = bus.InsIn;
          state_d = ST_DECODE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DECODE: begin
        fields_d    = slice_fields(ir_q);
        ext_sel_d   = lut_ext_sel_s;
        illegal_d   = lut_illegal_s;
        dec_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.DecAck) begin
          dec_valid_d = 1'b0;
          if (fields_q.opcode == OP_HALT) begin
            halted_d = 1'b1;
            state_d  = ST_HALT;
          end else begin
            state_d  = ST_IDLE;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_HALT: begin
        halted_d = 1'b1;
        state_d  = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Ready is registered so it is low throughout reset and rises one edge later.
    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      ir_q        <= RESET_PC_INS;
      ready_q     <= 1'b0;
      dec_valid_q <= 1'b0;
      halted_q    <= 1'b0;
      fields_q    <= '0;
      ext_sel_q   <= EXT_ZERO;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      ready_q     <= ready_d;
      dec_valid_q <= dec_valid_d;
      halted_q    <= halted_d;
      fields_q    <= fields_d;
      ext_sel_q   <= ext_sel_d;
      illegal_q   <= illegal_d;
    end
  end

  assign bus.InsReady   = ready_q;
  assign bus.DecValid   = dec_valid_q;
  assign bus.Halted     = halted_q;
  assign bus.Opcode     = fields_q.opcode;
  assign bus.Rs         = fields_q.rs;
  assign bus.Rt         = fields_q.rt;
  assign bus.Rd         = fields_q.rd;
  assign bus.Immediate  = fields_q.imm;
  assign bus.JumpTarget = fields_q.jtarget;
  assign bus.ExtSel     = ext_sel_q;
  assign bus.IllegalOp  = illegal_q;

endmodule
